uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_pkg.sv | 35 +++
 rtl/uart_tx_fifo_sync_fifo.sv | 64 ++++++
 rtl/uart_tx_fifo.sv | 113 +++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared constants and types for the UART transmit FIFO.
// Status bit positions are consumed by software headers; keep them in sync.
package uart_tx_fifo_pkg;

   localparam int unsigned BUS_WIDTH        = 32;
   localparam int unsigned BYTE_WIDTH       = 8;

   // Status word layout returned on a bus read
   localparam int unsigned STATUS_EMPTY_BIT = 0;
   localparam int unsigned STATUS_FULL_BIT  = 1;
   localparam int unsigned STATUS_COUNT_LSB = 8;
   localparam int unsigned STATUS_COUNT_MSB = 15;

   // Drain state machine towards the downstream transmitter
   typedef enum logic [1:0] {
      DRAIN_IDLE    = 2'd0,
      DRAIN_REQUEST = 2'd1,
      DRAIN_RELEASE = 2'd2
   } drain_state_t;

   // Assemble the status word from its fields
   function automatic logic [BUS_WIDTH-1:0] status_word(
      input logic [7:0] count,
      input logic       full,
      input logic       empty
   );
      logic [BUS_WIDTH-1:0] w_word;
      w_word = '0;
      w_word[STATUS_COUNT_MSB:STATUS_COUNT_LSB] = count;
      w_word[STATUS_FULL_BIT]                   = full;
      w_word[STATUS_EMPTY_BIT]                  = empty;
      return w_word;
   endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock byte FIFO: storage, wrapping pointers and an occupancy count.
// Full/empty come straight from the registered count, so a push while full
// is refused even when a pop happens on the same edge.
module sync_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_push,
   input  logic                  i_pop,
   input  logic [BYTE_WIDTH-1:0] i_wdata,
   output logic [BYTE_WIDTH-1:0] o_rdata,
   output logic [ADDR_WIDTH:0]   o_count,
   output logic                  o_full,
   output logic                  o_empty
);

   logic [BYTE_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  w_do_push;
   logic                  w_do_pop;

   assign o_full    = (r_count == (ADDR_WIDTH+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_rdata   = r_mem[r_rd_ptr];

   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;

   // Storage write; contents are not reset
   always_ff @(posedge i_clock) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // Pointers wrap naturally at DEPTH; count tracks net push/pop
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (ADDR_WIDTH+1)'(1);
            2'b01:   r_count <= r_count - (ADDR_WIDTH+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Bus-facing transmit FIFO in front of a UART transmitter.
// Writes push a byte (stalling while full), reads return a status word, and a
// small drain FSM hands queued bytes to the transmitter one at a time.
module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic                 i_request,
   input  logic                 i_rw,
   input  logic [BUS_WIDTH-1:0] i_wdata,
   output logic [BUS_WIDTH-1:0] o_rdata,
   output logic                 o_ready,
   output logic                 o_tx_request,
   output logic [BUS_WIDTH-1:0] o_tx_wdata,
   input  logic                 i_tx_ready,
   output logic                 o_empty
);

   logic                  r_done;
   drain_state_t          r_state;
   logic                  r_tx_request;
   logic [BUS_WIDTH-1:0]  r_tx_wdata;

   logic                  w_push;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_empty;
   logic [ADDR_WIDTH:0]   w_count;
   logic [BYTE_WIDTH-1:0] w_head;
   logic                  w_read_active;
   logic                  w_unused_wdata;

   assign w_unused_wdata = ^i_wdata[BUS_WIDTH-1:BYTE_WIDTH];

   // A write is taken once per request, only when there is room
   assign w_push = i_request & i_rw & ~r_done & ~w_full;
   // The transmitter's ready while requesting is the byte handoff
   assign w_pop  = (r_state == DRAIN_REQUEST) & i_tx_ready;

   sync_fifo #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_fifo (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (i_wdata[BYTE_WIDTH-1:0]),
      .o_rdata (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Done flag: set when the access completes, cleared once the request drops
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_done <= 1'b0;
      end else if (!i_request) begin
         r_done <= 1'b0;
      end else if (!r_done && (!i_rw || !w_full)) begin
         r_done <= 1'b1;
      end
   end

   assign o_ready       = r_done & i_request;
   assign w_read_active = o_ready & ~i_rw;
   // count[7:0] truncates/zero-extends the DEPTH+1 range into the 8-bit field
   assign o_rdata       = w_read_active ? status_word(8'(w_count), w_full, w_empty) : '0;
   assign o_empty       = w_empty;

   // Drain FSM: latch head byte, request until accepted, wait for ready to drop
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= DRAIN_IDLE;
         r_tx_request <= 1'b0;
         r_tx_wdata   <= '0;
      end else begin
         case (r_state)
            DRAIN_IDLE: begin
               if (!w_empty) begin
                  r_tx_wdata   <= BUS_WIDTH'(w_head);
                  r_tx_request <= 1'b1;
                  r_state      <= DRAIN_REQUEST;
               end
            end
            DRAIN_REQUEST: begin
               if (i_tx_ready) begin
                  r_tx_request <= 1'b0;
                  r_state      <= DRAIN_RELEASE;
               end
            end
            DRAIN_RELEASE: begin
               if (!i_tx_ready) begin
                  r_state <= DRAIN_IDLE;
               end
            end
            default: begin
               r_tx_request <= 1'b0;
               r_state      <= DRAIN_IDLE;
            end
         endcase
      end
   end

   assign o_tx_request = r_tx_request;
   assign o_tx_wdata   = r_tx_wdata;

endmodule
